// File: rtl/knight_motion_ctrl.sv
// Knight sprite motion controller: decodes keycodes and, once per synchronized
// frame tick, integrates walk, jump and gravity into registered sprite outputs.
module knight_motion_ctrl #(
  parameter int unsigned X_START    = 320,
  parameter int unsigned GROUND_Y   = 400,
  parameter int unsigned X_MIN      = 25,
  parameter int unsigned X_MAX      = 614,
  parameter int unsigned Y_MIN      = 32,
  parameter int unsigned STEP_X     = 3,
  parameter int unsigned JUMP_SPEED = 12,
  parameter int unsigned GRAVITY    = 1,
  parameter int unsigned MAX_FALL   = 10
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_clk,
  input  logic [31:0] keycode,
  output logic [9:0]  Player_X,
  output logic [9:0]  Player_Y,
  output logic [9:0]  Player_SizeX,
  output logic [9:0]  Player_SizeY,
  output logic [3:0]  Player_Status,
  output logic        Inverse
);

  localparam int unsigned PW = 10;
  localparam int unsigned VW = 8;
  localparam int unsigned YW = 11;

  localparam logic signed [VW-1:0] GRAV_S     = VW'(GRAVITY);
  localparam logic signed [VW-1:0] MAX_FALL_S = VW'(MAX_FALL);
  localparam logic signed [VW-1:0] VY_LAUNCH  = VW'(0) - VW'(JUMP_SPEED);
  localparam logic signed [YW-1:0] Y_MIN_S    = YW'(Y_MIN);
  localparam logic signed [YW-1:0] GROUND_S   = YW'(GROUND_Y);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_JUMP = 2'd2,
    ST_FALL = 2'd3
  } state_t;

  logic                 r_sync1, r_sync2, r_sync3, r_tick;
  state_t               r_state, w_state_n;
  logic [PW-1:0]        r_x, w_x_n;
  logic [PW-1:0]        r_y, w_y_n;
  logic signed [VW-1:0] r_vy, w_vy_n;
  logic                 r_inv, w_inv_n;
  logic                 r_armed, w_armed_n;

  logic                 w_left, w_right, w_jump;
  logic                 w_go_left, w_go_right, w_horiz;
  logic [YW-1:0]        w_x_inc;
  logic                 w_dec_ok;
  logic signed [YW-1:0] w_y_next;
  logic signed [VW-1:0] w_vy_grav;

  // A key counts as pressed if any of the four report slots carries it
  always_comb begin
    w_left  = 1'b0;
    w_right = 1'b0;
    w_jump  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (keycode[8*i +: 8] == 8'h04) w_left  = 1'b1;
      if (keycode[8*i +: 8] == 8'h07) w_right = 1'b1;
      if (keycode[8*i +: 8] == 8'h1A || keycode[8*i +: 8] == 8'h2C) w_jump = 1'b1;
    end
  end

  assign w_go_left  = w_left & ~w_right;
  assign w_go_right = w_right & ~w_left;
  assign w_horiz    = w_go_left | w_go_right;

  assign w_x_inc   = {1'b0, r_x} + YW'(STEP_X);
  assign w_dec_ok  = {1'b0, r_x} >= YW'(X_MIN + STEP_X);
  assign w_y_next  = $signed({1'b0, r_y}) + $signed({{(YW-VW){r_vy[VW-1]}}, r_vy});
  assign w_vy_grav = r_vy + GRAV_S;

  // Next-state and next-kinematics, only advanced on a frame tick
  always_comb begin
    w_state_n = r_state;
    w_x_n     = r_x;
    w_y_n     = r_y;
    w_vy_n    = r_vy;
    w_inv_n   = r_inv;
    w_armed_n = r_armed;
    if (r_tick) begin
      if (!w_jump) w_armed_n = 1'b1;
      if (w_go_left) begin
        w_inv_n = 1'b1;
        w_x_n   = w_dec_ok ? (r_x - PW'(STEP_X)) : PW'(X_MIN);
      end else if (w_go_right) begin
        w_inv_n = 1'b0;
        w_x_n   = (w_x_inc > YW'(X_MAX)) ? PW'(X_MAX) : w_x_inc[PW-1:0];
      end
      case (r_state)
        ST_IDLE, ST_WALK: begin
          if (w_jump && r_armed) begin
            w_state_n = ST_JUMP;
            w_vy_n    = VY_LAUNCH;
            w_armed_n = 1'b0;
          end else if (w_horiz) begin
            w_state_n = ST_WALK;
          end else begin
            w_state_n = ST_IDLE;
          end
        end
        ST_JUMP: begin
          if (w_y_next < Y_MIN_S) begin
            w_y_n     = PW'(Y_MIN);
            w_vy_n    = '0;
            w_state_n = ST_FALL;
          end else begin
            w_y_n  = w_y_next[PW-1:0];
            w_vy_n = w_vy_grav;
            if (!w_vy_grav[VW-1]) w_state_n = ST_FALL;
          end
        end
        ST_FALL: begin
          if (w_y_next >= GROUND_S) begin
            w_y_n     = PW'(GROUND_Y);
            w_vy_n    = '0;
            w_state_n = w_horiz ? ST_WALK : ST_IDLE;
          end else begin
            w_y_n  = w_y_next[PW-1:0];
            w_vy_n = (w_vy_grav > MAX_FALL_S) ? MAX_FALL_S : w_vy_grav;
          end
        end
        default: w_state_n = ST_IDLE;
      endcase
    end
  end

  // Frame synchronizer, registered edge pulse, and motion state registers
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_tick  <= 1'b0;
      r_state <= ST_IDLE;
      r_x     <= PW'(X_START);
      r_y     <= PW'(GROUND_Y);
      r_vy    <= '0;
      r_inv   <= 1'b0;
      r_armed <= 1'b1;
    end else begin
      r_sync1 <= frame_clk;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_tick  <= r_sync2 & ~r_sync3;
      r_state <= w_state_n;
      r_x     <= w_x_n;
      r_y     <= w_y_n;
      r_vy    <= w_vy_n;
      r_inv   <= w_inv_n;
      r_armed <= w_armed_n;
    end
  end

  assign Player_X      = r_x;
  assign Player_Y      = r_y;
  assign Player_SizeX  = PW'(50);
  assign Player_SizeY  = PW'(64);
  assign Player_Status = {2'b00, r_state};
  assign Inverse       = r_inv;

endmodule

// File: tb/tb_knight_motion_ctrl.sv
// Directed bench for knight_motion_ctrl: reset, walking/clamp, jump arc,
// held jump, key combinations, frame synchronization latency, reset mid-jump.
`timescale 1ns/1ps
module tb_knight_motion_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_clk = 1'b0;
  logic [31:0] keycode = 32'h0;
  logic [9:0]  Player_X, Player_Y, Player_SizeX, Player_SizeY;
  logic [3:0]  Player_Status;
  logic        Inverse;

  int errors = 0;
  int checks = 0;

  knight_motion_ctrl dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_clk    (frame_clk),
    .keycode      (keycode),
    .Player_X     (Player_X),
    .Player_Y     (Player_Y),
    .Player_SizeX (Player_SizeX),
    .Player_SizeY (Player_SizeY),
    .Player_Status(Player_Status),
    .Inverse      (Inverse)
  );

  always #5 Clk = ~Clk;

  // One full frame: raise frame_clk long enough for the update to land, then drop it
  task automatic do_frame(input logic [31:0] k);
    keycode = k;
    @(negedge Clk) frame_clk = 1'b1;
    repeat (5) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic test_reset;
    Reset_n = 1'b0;
    keycode = 32'h0;
    repeat (3) @(negedge Clk);
    if (Player_SizeX !== 10'd50) begin errors++; $display("FAIL reset_sizex: got %0d expected 50", Player_SizeX); end
    checks++;
    if (Player_SizeY !== 10'd64) begin errors++; $display("FAIL reset_sizey: got %0d expected 64", Player_SizeY); end
    checks++;
    Reset_n = 1'b1;
    @(negedge Clk);
    if (Player_X !== 10'd320) begin errors++; $display("FAIL reset_x: got %0d expected 320", Player_X); end
    checks++;
    if (Player_Y !== 10'd400) begin errors++; $display("FAIL reset_y: got %0d expected 400", Player_Y); end
    checks++;
    if (Player_Status !== 4'd0) begin errors++; $display("FAIL reset_status: got %0d expected 0", Player_Status); end
    checks++;
    if (Inverse !== 1'b0) begin errors++; $display("FAIL reset_inv: got %0d expected 0", Inverse); end
    checks++;
    for (int i = 0; i < 5; i++) do_frame(32'h0);
    if (Player_X !== 10'd320 || Player_Y !== 10'd400 || Player_Status !== 4'd0) begin
      errors++;
      $display("FAIL idle_frames: got x=%0d y=%0d st=%0d expected x=320 y=400 st=0", Player_X, Player_Y, Player_Status);
    end
    checks++;
  endtask

  task automatic test_walk_clamp;
    do_frame(32'h0000_0004);
    if (Player_X !== 10'd317) begin errors++; $display("FAIL walk_x1: got %0d expected 317", Player_X); end
    checks++;
    if (Player_Status !== 4'd1) begin errors++; $display("FAIL walk_status: got %0d expected 1", Player_Status); end
    checks++;
    if (Inverse !== 1'b1) begin errors++; $display("FAIL walk_inv: got %0d expected 1", Inverse); end
    checks++;
    for (int i = 0; i < 119; i++) do_frame(32'h0000_0004);
    if (Player_X !== 10'd25) begin errors++; $display("FAIL walk_clamp_x: got %0d expected 25", Player_X); end
    checks++;
    if (Player_Status !== 4'd1 || Inverse !== 1'b1) begin
      errors++; $display("FAIL walk_clamp_st: got st=%0d inv=%0d expected st=1 inv=1", Player_Status, Inverse);
    end
    checks++;
    do_frame(32'h0);
    if (Player_Status !== 4'd0 || Inverse !== 1'b1 || Player_X !== 10'd25) begin
      errors++; $display("FAIL walk_release: got st=%0d inv=%0d x=%0d expected st=0 inv=1 x=25", Player_Status, Inverse, Player_X);
    end
    checks++;
  endtask

  task automatic test_jump_arc;
    do_frame(32'h0000_002C);
    if (Player_Status !== 4'd2 || Player_Y !== 10'd400) begin
      errors++; $display("FAIL jump_launch: got st=%0d y=%0d expected st=2 y=400", Player_Status, Player_Y);
    end
    checks++;
    do_frame(32'h0);
    if (Player_Y !== 10'd388) begin errors++; $display("FAIL jump_first_rise: got %0d expected 388", Player_Y); end
    checks++;
    for (int i = 0; i < 11; i++) do_frame(32'h0);
    if (Player_Y !== 10'd322 || Player_Status !== 4'd3) begin
      errors++; $display("FAIL jump_apex: got y=%0d st=%0d expected y=322 st=3", Player_Y, Player_Status);
    end
    checks++;
    for (int i = 0; i < 11; i++) do_frame(32'h0);
    if (Player_Y !== 10'd377) begin errors++; $display("FAIL fall_11: got %0d expected 377", Player_Y); end
    checks++;
    do_frame(32'h0);
    do_frame(32'h0);
    if (Player_Y !== 10'd397 || Player_Status !== 4'd3) begin
      errors++; $display("FAIL fall_13: got y=%0d st=%0d expected y=397 st=3", Player_Y, Player_Status);
    end
    checks++;
    do_frame(32'h0);
    if (Player_Y !== 10'd400 || Player_Status !== 4'd0) begin
      errors++; $display("FAIL land: got y=%0d st=%0d expected y=400 st=0", Player_Y, Player_Status);
    end
    checks++;
  endtask

  task automatic test_held_jump;
    do_frame(32'h0000_001A);
    if (Player_Status !== 4'd2) begin errors++; $display("FAIL held_launch: got %0d expected 2", Player_Status); end
    checks++;
    for (int i = 0; i < 26; i++) do_frame(32'h0000_001A);
    if (Player_Status !== 4'd0 || Player_Y !== 10'd400) begin
      errors++; $display("FAIL held_land: got st=%0d y=%0d expected st=0 y=400", Player_Status, Player_Y);
    end
    checks++;
    for (int i = 0; i < 3; i++) do_frame(32'h0000_001A);
    if (Player_Status !== 4'd0) begin errors++; $display("FAIL held_no_relaunch: got %0d expected 0", Player_Status); end
    checks++;
    do_frame(32'h0);
    do_frame(32'h0000_001A);
    if (Player_Status !== 4'd2) begin errors++; $display("FAIL held_rearm: got %0d expected 2", Player_Status); end
    checks++;
    for (int i = 0; i < 26; i++) do_frame(32'h0);
    if (Player_Status !== 4'd0 || Player_Y !== 10'd400) begin
      errors++; $display("FAIL held_land2: got st=%0d y=%0d expected st=0 y=400", Player_Status, Player_Y);
    end
    checks++;
  endtask

  task automatic test_simultaneous;
    do_frame(32'h0004_0007);
    if (Player_X !== 10'd25 || Player_Status !== 4'd0 || Inverse !== 1'b1) begin
      errors++; $display("FAIL both_dirs: got x=%0d st=%0d inv=%0d expected x=25 st=0 inv=1", Player_X, Player_Status, Inverse);
    end
    checks++;
    do_frame(32'h0000_2C07);
    if (Player_X !== 10'd28 || Player_Status !== 4'd2 || Inverse !== 1'b0) begin
      errors++; $display("FAIL jump_right: got x=%0d st=%0d inv=%0d expected x=28 st=2 inv=0", Player_X, Player_Status, Inverse);
    end
    checks++;
    do_frame(32'h0000_0007);
    if (Player_X !== 10'd31 || Player_Y !== 10'd388) begin
      errors++; $display("FAIL air_move: got x=%0d y=%0d expected x=31 y=388", Player_X, Player_Y);
    end
    checks++;
    for (int i = 0; i < 25; i++) do_frame(32'h0000_0007);
    if (Player_X !== 10'd106 || Player_Y !== 10'd400 || Player_Status !== 4'd1) begin
      errors++; $display("FAIL land_walk: got x=%0d y=%0d st=%0d expected x=106 y=400 st=1", Player_X, Player_Y, Player_Status);
    end
    checks++;
  endtask

  task automatic test_sync_latency;
    logic [9:0] x0;
    logic [9:0] exp_x;
    int ph;
    keycode = 32'h0000_0004;
    repeat (5) @(negedge Clk);
    keycode = 32'h0;
    if (Player_X !== 10'd106) begin errors++; $display("FAIL no_tick_no_move: got %0d expected 106", Player_X); end
    checks++;
    for (int f = 0; f < 3; f++) begin
      keycode = 32'h0000_0007;
      x0 = 10'(106 + 3 * f);
      @(posedge Clk);
      ph = $urandom_range(1, 9);
      #(ph) frame_clk = 1'b1;
      for (int e = 1; e <= 10; e++) begin
        @(posedge Clk);
        #1;
        exp_x = (e >= 4) ? 10'(x0 + 10'd3) : x0;
        if (Player_X !== exp_x) begin
          errors++; $display("FAIL sync_f%0d_e%0d: got %0d expected %0d", f, e, Player_X, exp_x);
        end
        checks++;
      end
      frame_clk = 1'b0;
      repeat (4) @(posedge Clk);
    end
  endtask

  task automatic test_reset_mid_jump;
    do_frame(32'h0000_002C);
    for (int i = 0; i < 3; i++) do_frame(32'h0);
    if (Player_Y !== 10'd367 || Player_Status !== 4'd2) begin
      errors++; $display("FAIL mid_jump: got y=%0d st=%0d expected y=367 st=2", Player_Y, Player_Status);
    end
    checks++;
    @(negedge Clk) Reset_n = 1'b0;
    @(posedge Clk);
    #1;
    if (Player_X !== 10'd320 || Player_Y !== 10'd400 || Player_Status !== 4'd0 || Inverse !== 1'b0) begin
      errors++; $display("FAIL reset_mid_jump: got x=%0d y=%0d st=%0d inv=%0d expected 320 400 0 0",
                         Player_X, Player_Y, Player_Status, Inverse);
    end
    checks++;
    @(negedge Clk) Reset_n = 1'b1;
    do_frame(32'h0);
    if (Player_Y !== 10'd400 || Player_Status !== 4'd0 || Player_X !== 10'd320) begin
      errors++; $display("FAIL after_reset: got x=%0d y=%0d st=%0d expected 320 400 0", Player_X, Player_Y, Player_Status);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_walk_clamp();
    test_jump_arc();
    test_held_jump();
    test_simultaneous();
    test_sync_latency();
    test_reset_mid_jump();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
